serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes D = A − B − b_in one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Counterpart to the team's combinational ripple-carry adder: subtraction instead of addition, sequential instead of combinational.
- Sits beside the adder in lab datapaths. A start/busy/done handshake lets a controller launch it and collect the result.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- b_in  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle pulse; result is valid.
- d  output  WIDTH  difference; held stable from done until the next accepted start.
- b_out  output  1  borrow-out of the MSB; held with d.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, busy=0, done=0, d=0, b_out=0, bit counter=0, borrow flop=0, operand shift regs=0. Aborts any operation in progress; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load A/B shift regs, borrow flop←b_in, counter←0, d←0 → SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each edge:
  - Full-subtractor cell on (A[0], B[0], borrow).
  - Difference bit shifted into d MSB-first (right shift), so after WIDTH edges d[0] is the original bit 0.
  - Borrow flop ← cell borrow-out; A and B shift right; counter increments.
  - On the edge where counter==WIDTH−1: b_out ← final borrow → DONE.
- DONE, lasts one cycle with done=1:
  - start=1 → accepted: reload and → SHIFT, allowing back-to-back operations with no IDLE gap.
  - otherwise → IDLE.
- Latency: start accepted at edge k; busy high for cycles k+1 .. k+WIDTH; done high during cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while in SHIFT is ignored. Inputs a/b/b_in may change freely after capture without affecting the result.
- Arithmetic: unsigned modulo 2^WIDTH. b_out=1 iff a < b + b_in (unsigned).
- Cell equations: diff = x^y^bi; bo = (~x & y) | (~(x^y) & bi).
- d is not updated (not cleared) on return to IDLE. It changes only at the next accepted start and during SHIFT.
- Reset deasserted on the same edge as start=1: start is accepted normally.

Optional Feature:
- SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  - Defined: adds output port ovf (1 bit, reset 0). Updated with b_out: ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]) using the captured operands and b_in=0 semantics, i.e. two's-complement overflow of A−B.
  - Requires keeping the captured MSBs in two extra flops.
  - Undefined: port and flops absent; behaviour otherwise identical.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
- One sub-module: full_subtractor (inputs x, y, bi; outputs diff, bo; purely combinational), instantiated once.

Test Plan (WIDTH=4):
- Basic subtraction: a=9, b=3, b_in=0, start pulse → done 5 cycles after the start edge, d=6, b_out=0; busy high exactly 4 cycles.
- Underflow: a=3, b=5, b_in=0 → d=4'b1110 (14), b_out=1.
- Borrow-in: a=0, b=0, b_in=1 → d=15, b_out=1. Also a=8, b=7, b_in=1 → d=0, b_out=0.
- Start while busy: start pulses at SHIFT cycles 1 and 3 with a=15, b=15 → ignored; original op (a=12, b=4) completes with d=8, b_out=0. Back-to-back: start held during DONE with a=1, b=2 → next done 5 cycles later with d=15, b_out=1.
- Reset mid-operation: assert resetn=0 asynchronously in SHIFT cycle 2 → immediately busy=0, done=0, d=0, b_out=0; no done pulse follows; a fresh start afterwards works normally.
- With SERIAL_SUBTRACTOR_SIGNED_OVF_EN: a=4'b0111 (7), b=4'b1000 (−8) → d=15, ovf=1. a=5, b=3 → d=2, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the default operand width.
package serial_subtractor_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    // Pure combinational cell equations.
    always_comb begin
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - b_in, one bit per clock, LSB first,
// using one full-subtractor cell and a registered borrow. start/busy/done
// handshake; done is a one-cycle pulse, d/b_out held until the next start.
// Optional build macro SERIAL_SUBTRACTOR_SIGNED_OVF_EN adds a registered
// two's-complement overflow flag (ovf) for A - B.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              borrow_q, borrow_d;
    logic              b_out_q, b_out_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cell_diff, cell_bo;
    logic              accept;
    logic              last_bit;

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              ovf_q, ovf_d;
`endif

    assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bi   (borrow_q),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    // Controller state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next-state: start is ignored while shifting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controller outputs decoded from state.
    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    // Datapath next-state: load on accepted start, shift one bit per SHIFT cycle.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        b_out_d  = b_out_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_d      = a;
            b_d      = b;
            d_d      = '0;
            borrow_d = b_in;
            cnt_d    = '0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end else if (state_q == StShift) begin
            // Difference bits enter at the MSB so bit 0 lands in d[0] after WIDTH shifts.
            d_d      = {cell_diff, d_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = cell_bo;
            cnt_d    = cnt_q + CntW'(1);
            if (last_bit) begin
                b_out_d = cell_bo;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
                // cell_diff is the result MSB on this final shift.
                ovf_d   = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
`endif
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            b_out_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            b_out_q  <= b_out_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign d     = d_q;
    assign b_out = b_out_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         b_out;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic         ovf;
`endif

    int n_vec;
    int n_err;

    serial_subtractor #(
        .WIDTH (W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .b_out  (b_out)
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: unsigned modulo 2^W difference and borrow-out.
    function automatic int model_d(input int ai, input int bi, input int ci);
        return (ai - bi - ci) & ((1 << W) - 1);
    endfunction

    function automatic int model_bo(input int ai, input int bi, input int ci);
        return (ai < bi + ci) ? 1 : 0;
    endfunction

    // Signed overflow of A - B with W-bit two's-complement operands.
    function automatic int model_ovf(input int ai, input int bi);
        int sa, sb, r;
        sa = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
        sb = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
        r  = sa - sb;
        return (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
    endfunction

    // Present operands at a negedge; they are taken on the next rising edge.
    task automatic present(input int ai, input int bi, input int ci);
        start = 1'b1;
        a     = W'(ai);
        b     = W'(bi);
        b_in  = ci[0];
    endtask

    task automatic launch(input int ai, input int bi, input int ci);
        @(negedge clock);
        present(ai, bi, ci);
    endtask

    // Wait for done after an accepted start; inject bit c issues a junk start in SHIFT cycle c.
    task automatic collect(input string tag, input int ai, input int bi, input int ci,
                           input int inject);
        int cyc;
        int busy_cnt;
        int seen;
        cyc      = 0;
        busy_cnt = 0;
        seen     = 0;
        while (seen == 0 && cyc < 20) begin
            @(negedge clock);
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            b_in  = 1'($urandom);
            cyc++;
            if (done) seen = 1;
            else begin
                if (busy) busy_cnt++;
                if (inject[cyc % 32]) present(15, 15, 0);
            end
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, cyc, W + 1);
        check({tag, " busy_cycles"}, busy_cnt, W);
        check({tag, " d"}, int'(d), model_d(ai, bi, ci));
        check({tag, " b_out"}, int'(b_out), model_bo(ai, bi, ci));
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        if (ci == 0) check({tag, " ovf"}, int'(ovf), model_ovf(ai, bi));
`endif
    endtask

    // After done: one-cycle pulse and result held while idle.
    task automatic check_hold(input string tag, input int ai, input int bi, input int ci);
        @(negedge clock);
        check({tag, " done_pulse"}, int'(done), 0);
        check({tag, " busy_idle"}, int'(busy), 0);
        @(negedge clock);
        check({tag, " d_held"}, int'(d), model_d(ai, bi, ci));
        check({tag, " b_out_held"}, int'(b_out), model_bo(ai, bi, ci));
    endtask

    initial begin
        int ra, rb, rc, na, nb, nc, done_cnt;
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        b_in   = 1'b0;
        #12;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst d", int'(d), 0);
        check("rst b_out", int'(b_out), 0);

        // Release reset together with a start request.
        @(negedge clock);
        resetn = 1'b1;
        present(9, 3, 0);
        collect("basic", 9, 3, 0, 0);
        check_hold("basic", 9, 3, 0);

        launch(3, 5, 0);
        collect("underflow", 3, 5, 0, 0);
        check_hold("underflow", 3, 5, 0);

        launch(0, 0, 1);
        collect("bin_zero", 0, 0, 1, 0);
        launch(8, 7, 1);
        collect("bin_8_7", 8, 7, 1, 0);

        // Junk starts in SHIFT cycles 1 and 3, then back-to-back from DONE.
        launch(12, 4, 0);
        collect("ignore_busy", 12, 4, 0, 32'b1010);
        present(1, 2, 0);
        collect("b2b", 1, 2, 0, 0);
        check_hold("b2b", 1, 2, 0);

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        launch(7, 8, 0);
        collect("ovf_pos", 7, 8, 0, 0);
        launch(5, 3, 0);
        collect("ovf_none", 5, 3, 0, 0);
`endif

        // Asynchronous reset in SHIFT cycle 2.
        launch(9, 3, 0);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort d", int'(d), 0);
        check("abort b_out", int'(b_out), 0);
        @(negedge clock);
        resetn   = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);
        launch(13, 6, 1);
        collect("after_abort", 13, 6, 1, 0);

        // Randomized operations, some chained back-to-back from DONE.
        ra = int'($urandom_range(0, 15));
        rb = int'($urandom_range(0, 15));
        rc = int'($urandom_range(0, 1));
        launch(ra, rb, rc);
        for (int i = 0; i < 40; i++) begin
            collect("rand", ra, rb, rc, int'($urandom) & 32'h1e);
            na = int'($urandom_range(0, 15));
            nb = int'($urandom_range(0, 15));
            nc = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                present(na, nb, nc);
            end else begin
                check_hold("rand", ra, rb, rc);
                launch(na, nb, nc);
            end
            ra = na;
            rb = nb;
            rc = nc;
        end
        collect("rand_last", ra, rb, rc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
